// File: rtl/apb_completer_regs_if.sv
// APB bus bundle for the register-file completer.
// The initiator drives select/phase/address/data; the completer answers.
interface apb_completer_regs_if;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [2:0]  pprot;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel,
    output penable,
    output paddr,
    output pwrite,
    output pprot,
    output pwdata,
    output pstrb,
    input  prdata,
    input  pready,
    input  pslverr
  );

  modport slave (
    input  psel,
    input  penable,
    input  paddr,
    input  pwrite,
    input  pprot,
    input  pwdata,
    input  pstrb,
    output prdata,
    output pready,
    output pslverr
  );
endinterface

// File: rtl/apb_completer_regs.sv
// APB completer with 14 RW words, a transfer counter and an ID word.
// Wait states are counted in ACCESS; pready depends on state only.
module apb_completer_regs #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input logic                 pclk,
  input logic                 preset,
  apb_completer_regs_if.slave apb
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;
  localparam logic [3:0] WS     = 4'(WAIT_STATES);

  logic [0:0]  state;
  logic [3:0]  count;
  logic [31:0] regs [14];
  logic [31:0] xfer_cnt;

  logic [3:0]  idx;
  logic        ready;
  logic        done;
  logic        err;
  logic        do_wr;
  logic [31:0] rd_word;
  logic        unused_ok;

  assign idx       = apb.paddr[5:2];
  assign ready     = (state == ACCESS) && (count == 4'd0);
  assign done      = ready && apb.psel && apb.penable;
  assign unused_ok = ^apb.pprot[2:1];

  always_comb begin
    err = 1'b0;
    if (|apb.paddr[31:6])
      err = 1'b1;
    if (|apb.paddr[1:0])
      err = 1'b1;
    if (apb.pwrite && (idx >= 4'd14))
      err = 1'b1;
    if ((idx < 4'd4) && !apb.pprot[0])
      err = 1'b1;
    if (!apb.pwrite && (|apb.pstrb))
      err = 1'b1;
  end

  assign do_wr = done && apb.pwrite && !err;

  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      idx == 4'd15: rd_word = ID_VALUE;
      idx == 4'd14: rd_word = xfer_cnt;
      default: begin
        for (int i = 0; i < 14; i++)
          if (idx == 4'(i))
            rd_word = regs[i];
      end
    endcase
  end

  assign apb.pready  = ready;
  assign apb.pslverr = ready && err;
  assign apb.prdata  = (ready && !apb.pwrite && !err)
                       ? rd_word : 32'h0;

  // psel dropping in ACCESS abandons the transfer outright
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (apb.psel && !apb.penable) begin
            state <= ACCESS;
            count <= WS;
          end
        end
        ACCESS: begin
          if (!apb.psel)
            state <= IDLE;
          else if (count != 4'd0)
            count <= count - 4'd1;
          else if (apb.penable)
            state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      xfer_cnt <= 32'd0;
      for (int i = 0; i < 14; i++)
        regs[i] <= 32'd0;
    end else begin
      if (done)
        xfer_cnt <= xfer_cnt + 32'd1;
      if (do_wr) begin
        for (int i = 0; i < 14; i++)
          if (idx == 4'(i))
            for (int b = 0; b < 4; b++)
              if (apb.pstrb[b])
                regs[i][8*b +: 8] <= apb.pwdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_completer_regs.sv
// Bench for apb_completer_regs: two instances (1 and 0 wait states),
// a per-cycle output model and directed literal readbacks.
module tb_apb_completer_regs;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_completer_regs_if bus0 ();
  apb_completer_regs_if bus1 ();

  apb_completer_regs #(
    .WAIT_STATES(1),
    .ID_VALUE   (ID)
  ) u_dut0 (
    .pclk  (clk),
    .preset(rst),
    .apb   (bus0)
  );

  apb_completer_regs #(
    .WAIT_STATES(0),
    .ID_VALUE   (ID)
  ) u_dut1 (
    .pclk  (clk),
    .preset(rst),
    .apb   (bus1)
  );

  logic        sel   [2];
  logic        en    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [2:0]  prot  [2];
  logic [3:0]  strb  [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];
  logic        serr  [2];

  assign bus0.psel    = sel[0];
  assign bus0.penable = en[0];
  assign bus0.pwrite  = wr[0];
  assign bus0.paddr   = addr[0];
  assign bus0.pwdata  = wdata[0];
  assign bus0.pprot   = prot[0];
  assign bus0.pstrb   = strb[0];
  assign rdata[0]     = bus0.prdata;
  assign rdy[0]       = bus0.pready;
  assign serr[0]      = bus0.pslverr;

  assign bus1.psel    = sel[1];
  assign bus1.penable = en[1];
  assign bus1.pwrite  = wr[1];
  assign bus1.paddr   = addr[1];
  assign bus1.pwdata  = wdata[1];
  assign bus1.pprot   = prot[1];
  assign bus1.pstrb   = strb[1];
  assign rdata[1]     = bus1.prdata;
  assign rdy[1]       = bus1.pready;
  assign serr[1]      = bus1.pslverr;

  int ws [2] = '{1, 0};

  logic [31:0] mem  [2][14];
  logic [31:0] cnt  [2];
  logic        e_rdy [2];
  logic        e_err [2];
  logic [31:0] e_rd  [2];

  bit chk_en;
  int n_chk;
  int n_fail;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_err(logic [31:0] a, logic w,
                                 logic [2:0] p, logic [3:0] s);
    int r;
    r = int'(a[5:2]);
    return (a[31:6] != 0) || (a[1:0] != 0) || (w && r >= 14) ||
           (r < 4 && !p[0]) || (!w && s != 4'b0000);
  endfunction

  function automatic logic [31:0] m_read(int d, logic [3:0] r);
    if (r == 4'd15) return ID;
    if (r == 4'd14) return cnt[d];
    return mem[d][int'(r)];
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 32'd0;
      for (int i = 0; i < 14; i++) mem[d][i] = 32'd0;
    end
  endtask

  task automatic m_commit(int d, logic [31:0] a, logic w, logic [2:0] p,
                          logic [31:0] wd, logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (w && !m_err(a, w, p, s))
      mem[d][int'(a[5:2])] = (mem[d][int'(a[5:2])] & ~mask) | (wd & mask);
    cnt[d] = cnt[d] + 32'd1;
  endtask

  task automatic clr_exp(int d);
    e_rdy[d] = 1'b0;
    e_err[d] = 1'b0;
    e_rd[d]  = 32'd0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("pready%0d", d), {31'b0, rdy[d]}, {31'b0, e_rdy[d]});
        chk($sformatf("pslverr%0d", d), {31'b0, serr[d]}, {31'b0, e_err[d]});
        chk($sformatf("prdata%0d", d), rdata[d], e_rd[d]);
      end
    end
  end

  task automatic xfer(int d, bit b2b, logic [31:0] a, logic w,
                      logic [2:0] p, logic [31:0] wd, logic [3:0] s,
                      output logic [31:0] ard, output logic aerr);
    if (!b2b) begin
      @(posedge clk);
      #1;
    end
    sel[d] = 1'b1; en[d] = 1'b0; addr[d] = a; wr[d] = w;
    prot[d] = p; wdata[d] = wd; strb[d] = s;
    clr_exp(d);
    @(posedge clk);
    #1;
    en[d] = 1'b1;
    for (int i = 0; i < ws[d]; i++) begin
      @(posedge clk);
      #1;
    end
    e_rdy[d] = 1'b1;
    e_err[d] = m_err(a, w, p, s);
    e_rd[d]  = (!w && !e_err[d]) ? m_read(d, a[5:2]) : 32'd0;
    @(negedge clk);
    ard  = rdata[d];
    aerr = serr[d];
    @(posedge clk);
    m_commit(d, a, w, p, wd, s);
    #1;
    sel[d] = 1'b0; en[d] = 1'b0;
    clr_exp(d);
  endtask

  task automatic lit(string nm, int d, bit b2b, logic [31:0] a, logic w,
                     logic [2:0] p, logic [31:0] wd, logic [3:0] s,
                     logic [31:0] x_rd, logic x_err);
    logic [31:0] ard;
    logic        aerr;
    xfer(d, b2b, a, w, p, wd, s, ard, aerr);
    chk({nm, "_rd"}, ard, x_rd);
    chk({nm, "_err"}, {31'b0, aerr}, {31'b0, x_err});
  endtask

  task automatic go(int d, bit b2b, logic [31:0] a, logic w,
                    logic [2:0] p, logic [31:0] wd, logic [3:0] s);
    logic [31:0] ard;
    logic        aerr;
    xfer(d, b2b, a, w, p, wd, s, ard, aerr);
  endtask

  initial begin
    rst = 1'b1;
    chk_en = 1'b0;
    n_chk = 0;
    n_fail = 0;
    for (int d = 0; d < 2; d++) begin
      sel[d] = 1'b0; en[d] = 1'b0; wr[d] = 1'b0; addr[d] = 32'd0;
      wdata[d] = 32'd0; prot[d] = 3'd0; strb[d] = 4'd0;
      clr_exp(d);
    end
    m_reset();
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    go(0, 0, 32'h10, 1, 3'b001, 32'hDEADBEEF, 4'hF);
    lit("rd_beef", 0, 0, 32'h10, 0, 3'b001, 0, 4'h0, 32'hDEADBEEF, 0);
    go(0, 0, 32'h14, 1, 3'b001, 32'h11223344, 4'hF);
    lit("cnt3", 0, 0, 32'h38, 0, 3'b001, 0, 4'h0, 32'd3, 0);
    go(0, 0, 32'h14, 1, 3'b001, 32'hAABBCCDD, 4'b0101);
    lit("partial", 0, 0, 32'h14, 0, 3'b001, 0, 4'h0, 32'h11BB33DD, 0);
    lit("id_rd", 0, 0, 32'h3C, 0, 3'b000, 0, 4'h0, ID, 0);
    lit("id_wr", 0, 0, 32'h3C, 1, 3'b001, 32'h12345678, 4'hF, 0, 1);
    lit("id_rd2", 0, 0, 32'h3C, 0, 3'b001, 0, 4'h0, ID, 0);
    lit("oob", 0, 0, 32'h40, 0, 3'b001, 0, 4'h0, 0, 1);
    lit("unpriv", 0, 0, 32'h08, 1, 3'b000, 32'h12345678, 4'hF, 0, 1);
    lit("unpriv_rd", 0, 0, 32'h08, 0, 3'b001, 0, 4'h0, 0, 0);
    lit("priv_wr", 0, 0, 32'h08, 1, 3'b001, 32'h12345678, 4'hF, 0, 0);
    lit("priv_rd", 0, 0, 32'h08, 0, 3'b001, 0, 4'h0, 32'h12345678, 0);
    lit("rd_strb", 0, 0, 32'h20, 0, 3'b001, 0, 4'h1, 0, 1);
    lit("misalign", 0, 0, 32'h21, 1, 3'b001, 32'hFFFFFFFF, 4'hF, 0, 1);
    lit("strb0", 0, 0, 32'h20, 1, 3'b001, 32'hFFFFFFFF, 4'h0, 0, 0);
    lit("r8_zero", 0, 0, 32'h20, 0, 3'b001, 0, 4'h0, 0, 0);

    // abandoned transfer: psel drops during the wait cycle
    @(posedge clk);
    #1;
    sel[0] = 1'b1; en[0] = 1'b0; addr[0] = 32'h18; wr[0] = 1'b1;
    prot[0] = 3'b001; wdata[0] = 32'hFFFFFFFF; strb[0] = 4'hF;
    @(posedge clk);
    #1;
    sel[0] = 1'b0;
    @(posedge clk);
    #1;
    lit("cnt18", 0, 0, 32'h38, 0, 3'b001, 0, 4'h0, 32'd18, 0);
    lit("r6_abort", 0, 0, 32'h18, 0, 3'b001, 0, 4'h0, 0, 0);

    // reset lands on the completing edge of a write to reg 6
    @(posedge clk);
    #1;
    sel[0] = 1'b1; en[0] = 1'b0; addr[0] = 32'h18; wr[0] = 1'b1;
    prot[0] = 3'b001; wdata[0] = 32'hCAFEF00D; strb[0] = 4'hF;
    @(posedge clk);
    #1;
    en[0] = 1'b1;
    @(posedge clk);
    #1;
    e_rdy[0] = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    m_reset();
    #1;
    sel[0] = 1'b0; en[0] = 1'b0;
    clr_exp(0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lit("cnt_rst", 0, 0, 32'h38, 0, 3'b001, 0, 4'h0, 32'd0, 0);
    lit("r6_rst", 0, 0, 32'h18, 0, 3'b001, 0, 4'h0, 32'd0, 0);

    // zero wait states, back-to-back transfers
    go(1, 0, 32'h00, 1, 3'b001, 32'h01020304, 4'hF);
    go(1, 1, 32'h04, 1, 3'b001, 32'h0A0B0C0D, 4'hF);
    lit("b2b_r0", 1, 1, 32'h00, 0, 3'b001, 0, 4'h0, 32'h01020304, 0);
    lit("b2b_r1", 1, 1, 32'h04, 0, 3'b001, 0, 4'h0, 32'h0A0B0C0D, 0);
    lit("b2b_cnt", 1, 1, 32'h38, 0, 3'b001, 0, 4'h0, 32'd4, 0);

    @(posedge clk);
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_completer_regs.md
APB_COMPLETER_REGS -- requirements
Module: apb_completer_regs

Interface
REQ-001 The block SHALL have one clock, pclk; reset is synchronous and active-high, port preset.
REQ-002 Parameter WAIT_STATES, default 1, SHALL set the access-phase cycles with pready low before completion (0-15).
REQ-003 Parameter ID_VALUE, default 32'hA9B0_0001, SHALL be the value of read-only register 15.
REQ-004 pclk  input  1  rising-edge clock.
REQ-005 preset  input  1  synchronous active-high reset.
REQ-006 psel  input  1  completer select.
REQ-007 penable  input  1  access phase indicator.
REQ-008 paddr  input  32  byte address.
REQ-009 pwrite  input  1  1 = write, 0 = read.
REQ-010 pprot  input  3  protection; bit 0 = privileged.
REQ-011 pwdata  input  32  write data.
REQ-012 pstrb  input  4  write byte strobes.
REQ-013 prdata  output  32  read data.
REQ-014 pready  output  1  transfer completion.
REQ-015 pslverr  output  1  transfer error, valid only with pready.

Function
REQ-016 The register map SHALL be 16 x 32-bit words at paddr[5:2]: regs 0-13 read/write, reg 14 a read-only transfer counter, reg 15 read-only ID_VALUE.
REQ-017 The FSM SHALL have states IDLE and ACCESS; IDLE -> ACCESS on a clock edge with psel=1, penable=0; the wait counter loads WAIT_STATES on that edge.
REQ-018 In ACCESS, the counter SHALL decrement each cycle while nonzero; pready = (state==ACCESS && count==0), with no combinational path from inputs.
REQ-019 On the edge where pready=1 and psel=penable=1, the transfer SHALL complete and the FSM SHALL return to IDLE, enabling back-to-back transfers with one setup cycle between accesses.
REQ-020 If psel drops while in ACCESS, the FSM SHALL return to IDLE on that edge with no register update and no counter increment.
REQ-021 Error conditions, evaluated on the completing edge, SHALL be: paddr[31:6] nonzero; paddr[1:0] nonzero; write to reg 14 or 15; access to regs 0-3 with pprot[0]=0; read with pstrb not equal to 4'b0000.
REQ-022 pslverr SHALL equal (pready && error condition) and SHALL be 0 at all other times.
REQ-023 A non-error write SHALL update only the bytes whose pstrb bit is set; pstrb=0000 SHALL leave the register unchanged without raising an error.
REQ-024 An erroring write SHALL modify no register.
REQ-025 prdata SHALL be the addressed register when pready=1, pwrite=0 and no error; otherwise prdata SHALL be 32'h0.
REQ-026 Reg 14 SHALL increment by 1 on every completed transfer, including errored ones, and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-027 A read of reg 14 SHALL return the pre-increment value.
REQ-028 paddr, pwrite, pprot, pwdata and pstrb SHALL be sampled combinationally on the completing cycle; the block assumes the initiator holds them stable through the access phase.

Reset
REQ-029 preset=1 on a rising edge SHALL force state to IDLE, wait counter to 0, regs 0-13 to 0 and reg 14 to 0.
REQ-030 While in reset and on the first cycle after it, pready, pslverr and prdata SHALL be 0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer with no register write.

Verification
REQ-032 WAIT_STATES=1, privileged write 32'hDEADBEEF to addr 0x10 with pstrb=1111, then read it -> each access shows pready low for 1 cycle then high; read returns 32'hDEADBEEF with pslverr=0.
REQ-033 Partial write: reg 5 = 32'h11223344, then write 32'hAABBCCDD with pstrb=0101 -> read returns 32'h11BB33DD.
REQ-034 Read 0x3C -> 32'hA9B0_0001. Write 0x3C -> pslverr=1 and value unchanged. Access 0x40 -> pslverr=1 and prdata=0.
REQ-035 Access reg 2 with pprot=000 -> pslverr=1 and no write. Repeat with pprot=001 -> success.
REQ-036 Preload reg 14 via 0xFFFFFFFF transfers in a forced-state test, or check the increment sequence: after reset, 3 transfers -> reading reg 14 returns 3. Then assert reset mid-access of a write to reg 6 -> reg 6 reads 0 and reg 14 reads 0.
REQ-037 WAIT_STATES=0 with back-to-back writes -> pready is high on the first access cycle of each transfer and both writes land.
